// File: rtl/lisa_i2c_seq.sv
// rtl/lisa_i2c_seq.sv - I2C single-byte register read/write sequencer over the controller register port.
// Optional poll timeout (err=11) enabled by defining LISA_I2C_SEQ_TIMEOUT_EN.
module lisa_i2c_seq #(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic [6:0] m_addr,
    output logic [7:0] m_di,
    output logic       m_periph,
    output logic       m_we,
    input  logic [7:0] m_do
);

    localparam logic [6:0] A_RX     = 7'h23;
    localparam logic [6:0] A_STATUS = 7'h24;
    localparam logic [6:0] A_TX     = 7'h25;
    localparam logic [6:0] A_CMD    = 7'h26;

    localparam logic [7:0] CMD_IACK = 8'h01;
    localparam logic [7:0] CMD_STO  = 8'h40;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_TX,
        S_LD_CMD,
        S_POLL,
        S_IACK,
        S_CHECK,
        S_STOP,
        S_STOP_POLL,
        S_RSP
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       st_al_q, st_al_d;
    logic       st_rxack_q, st_rxack_d;
    logic       stopping_q, stopping_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_err_q, rsp_err_d;

    logic       rd_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;

    logic       accept;
    logic       timeout_hit;
    logic       last_step;
    logic       write_step;
    logic [7:0] tx_byte;
    logic [7:0] cmd_byte;

    assign accept     = req_valid && (state_q == S_IDLE);
    assign last_step  = rd_q ? (step_q == 2'd3) : (step_q == 2'd2);
    // The read's final byte is master-receive, so RXACK there is our own NACK.
    assign write_step = !(rd_q && (step_q == 2'd3));

    always_comb begin
        tx_byte  = 8'h00;
        cmd_byte = 8'h00;
        case (step_q)
            2'd0: begin
                tx_byte  = {dev_q, 1'b0};
                cmd_byte = 8'h90;
            end
            2'd1: begin
                tx_byte  = reg_q;
                cmd_byte = 8'h10;
            end
            2'd2: begin
                tx_byte  = rd_q ? {dev_q, 1'b1} : wdata_q;
                cmd_byte = rd_q ? 8'h90 : 8'h50;
            end
            default: begin
                tx_byte  = 8'h00;
                cmd_byte = 8'h68;
            end
        endcase
    end

`ifdef LISA_I2C_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    // Counts poll cycles already spent; zero on the first cycle of each poll phase.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_POLL || state_q == S_STOP_POLL) begin
            tmo_d = tmo_q + TMO_ONE;
        end
    end

    assign timeout_hit = ((tmo_q + TMO_ONE) == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        st_al_d    = st_al_q;
        st_rxack_d = st_rxack_q;
        stopping_d = stopping_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        m_periph   = 1'b0;
        m_we       = 1'b0;
        m_addr     = 7'h00;
        m_di       = 8'h00;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d    = S_LD_TX;
                    step_d     = 2'd0;
                    stopping_d = 1'b0;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = ERR_OK;
                end
            end
            S_LD_TX: begin
                m_periph = 1'b1;
                m_we     = 1'b1;
                m_addr   = A_TX;
                m_di     = tx_byte;
                state_d  = S_LD_CMD;
            end
            S_LD_CMD: begin
                m_periph = 1'b1;
                m_we     = 1'b1;
                m_addr   = A_CMD;
                m_di     = cmd_byte;
                state_d  = S_POLL;
            end
            S_POLL, S_STOP_POLL: begin
                m_periph = 1'b1;
                m_addr   = A_STATUS;
                if (m_do[0]) begin
                    st_al_d    = m_do[5];
                    st_rxack_d = m_do[7];
                    state_d    = S_IACK;
                end else if (timeout_hit) begin
                    rsp_err_d = ERR_TMO;
                    state_d   = S_RSP;
                end
            end
            S_IACK: begin
                m_periph = 1'b1;
                m_we     = 1'b1;
                m_addr   = A_CMD;
                m_di     = CMD_IACK;
                state_d  = stopping_q ? S_RSP : S_CHECK;
            end
            S_CHECK: begin
                if (st_al_q) begin
                    rsp_err_d = ERR_AL;
                    state_d   = S_RSP;
                end else if (write_step && st_rxack_q) begin
                    rsp_err_d = ERR_NACK;
                    state_d   = S_STOP;
                end else if (last_step) begin
                    if (rd_q) begin
                        m_periph   = 1'b1;
                        m_addr     = A_RX;
                        rsp_data_d = m_do;
                    end
                    state_d = S_RSP;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = (rd_q && step_q == 2'd2) ? S_LD_CMD : S_LD_TX;
                end
            end
            S_STOP: begin
                m_periph   = 1'b1;
                m_we       = 1'b1;
                m_addr     = A_CMD;
                m_di       = CMD_STO;
                stopping_d = 1'b1;
                state_d    = S_STOP_POLL;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 2'd0;
            st_al_q    <= 1'b0;
            st_rxack_q <= 1'b0;
            stopping_q <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= ERR_OK;
            rd_q       <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            st_al_q    <= st_al_d;
            st_rxack_q <= st_rxack_d;
            stopping_q <= stopping_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if (accept) begin
                rd_q    <= req_rd;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule
